// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command/response handshake plus the operand/result bus
// shared between the ALU sequencer and the external combinational ALU.
interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic [3:0] alu_nzvc;
  logic [7:0] acc;
  logic [3:0] ccr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_taken;

  // Sequencer side: consumes commands and ALU results, produces responses
  modport slave (
    input  req_valid, req_op, req_operand, alu_result, alu_nzvc, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, acc, ccr, rsp_valid, rsp_data, rsp_taken
  );

  // Issuer side: produces commands and ALU results, consumes responses
  modport master (
    output req_valid, req_op, req_operand, alu_result, alu_nzvc, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, acc, ccr, rsp_valid, rsp_data, rsp_taken
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command at a time, feeds registered operands to an
// external ALU, writes the result back into the accumulator and condition code
// register, and returns the accumulator (plus a branch-test bit) as a response.
module alu_sequencer #(
  parameter logic [7:0] RESET_ACC = 8'h00
) (
  input logic            clock,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD   = 3'd6;
  localparam logic [2:0] OP_BRANCH = 3'd7;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_acc;
  logic [3:0] r_ccr;
  logic [7:0] r_aluA;
  logic [7:0] r_aluB;
  logic [2:0] r_aluSel;
  logic       r_rspTaken;
  logic       w_reqReady;
  logic       w_rspValid;
  logic       w_accept;
  logic       w_isAluOp;
  logic       w_condTaken;

  assign w_accept  = w_reqReady && bus.req_valid;
  assign w_isAluOp = (bus.req_op != OP_LOAD) && (bus.req_op != OP_BRANCH);

  // State register; reset drops straight back to IDLE, abandoning any command
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; ALU ops detour through EXEC, LOAD and BRANCH-TEST go straight to RESP
  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 1'b0;
    w_rspValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_reqReady = 1'b1;
        if (bus.req_valid) begin
          w_nextState = w_isAluOp ? EXEC : RESP;
        end
      end
      EXEC: begin
        w_nextState = RESP;
      end
      RESP: begin
        w_rspValid = 1'b1;
        if (bus.rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Branch condition evaluated against the flags as they stand at accept; ccr is [N,Z,V,C]
  always_comb begin
    w_condTaken = 1'b0;
    case (bus.req_operand[2:0])
      3'd0:    w_condTaken = 1'b1;
      3'd1:    w_condTaken = r_ccr[3];
      3'd2:    w_condTaken = !r_ccr[3];
      3'd3:    w_condTaken = r_ccr[2];
      3'd4:    w_condTaken = !r_ccr[2];
      3'd5:    w_condTaken = r_ccr[1];
      3'd6:    w_condTaken = !r_ccr[1];
      default: w_condTaken = r_ccr[0];
    endcase
  end

  // Accumulator and flags: LOAD writes at accept (keeping V/C), ALU ops write back from EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= RESET_ACC;
      r_ccr <= 4'b0000;
    end else if (w_accept && (bus.req_op == OP_LOAD)) begin
      r_acc <= bus.req_operand;
      r_ccr <= {bus.req_operand[7], (bus.req_operand == 8'h00), r_ccr[1:0]};
    end else if (r_state == EXEC) begin
      r_acc <= bus.alu_result;
      r_ccr <= bus.alu_nzvc;
    end
  end

  // Operands to the external ALU are captured only when an ALU op is accepted and held otherwise
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_aluA   <= 8'h00;
      r_aluB   <= 8'h00;
      r_aluSel <= 3'd0;
    end else if (w_accept && w_isAluOp) begin
      r_aluA   <= r_acc;
      r_aluB   <= bus.req_operand;
      r_aluSel <= bus.req_op;
    end
  end

  // Branch result latched at accept of BRANCH-TEST, cleared by any other command
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rspTaken <= 1'b0;
    end else if (w_accept) begin
      r_rspTaken <= (bus.req_op == OP_BRANCH) ? w_condTaken : 1'b0;
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.rsp_valid = w_rspValid;
  assign bus.rsp_data  = r_acc;
  assign bus.rsp_taken = r_rspTaken;
  assign bus.acc       = r_acc;
  assign bus.ccr       = r_ccr;
  assign bus.alu_a     = r_aluA;
  assign bus.alu_b     = r_aluB;
  assign bus.alu_sel   = r_aluSel;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives directed and random commands into alu_sequencer,
// supplies a behavioural external ALU, and compares every response against
// an architectural model of the accumulator machine.
module tb_alu_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  logic [7:0] mAcc;
  logic [3:0] mCcr;
  logic [7:0] mAluA;
  logic [7:0] mAluB;
  logic [2:0] mAluSel;
  logic       mTaken;

  alu_sequencer_if busIf();

  alu_sequencer #(.RESET_ACC(8'h00)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (busIf)
  );

  always #5 clock = ~clock;

  // Behavioural external ALU: returns {N,Z,V,C, result}
  function automatic logic [11:0] aluFn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] wide;
    logic [7:0] r;
    logic       v;
    logic       c;
    v = 1'b0;
    c = 1'b0;
    case (sel)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8];
                  v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = a + 8'd1; v = (a == 8'h7F); c = (a == 8'hFF); end
      3'd5: begin r = a - 8'd1; v = (a == 8'h80); c = (a == 8'h00); end
      default: r = a;
    endcase
    return {r[7], (r == 8'h00), v, c, r};
  endfunction

  assign {busIf.alu_nzvc, busIf.alu_result} = aluFn(busIf.alu_sel, busIf.alu_a, busIf.alu_b);

  // Single comparison point: counts, and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mAcc    = 8'h00;
    mCcr    = 4'b0000;
    mAluA   = 8'h00;
    mAluB   = 8'h00;
    mAluSel = 3'd0;
    mTaken  = 1'b0;
  endtask

  // Architectural effect of one command on the accumulator machine
  task automatic modelCommand(input logic [2:0] op, input logic [7:0] operand);
    logic [11:0] res;
    if (op <= 3'd5) begin
      res     = aluFn(op, mAcc, operand);
      mAluA   = mAcc;
      mAluB   = operand;
      mAluSel = op;
      mAcc    = res[7:0];
      mCcr    = res[11:8];
      mTaken  = 1'b0;
    end else if (op == 3'd6) begin
      mAcc   = operand;
      mCcr   = {operand[7], (operand == 8'h00), mCcr[1:0]};
      mTaken = 1'b0;
    end else begin
      case (operand[2:0])
        3'd0: mTaken = 1'b1;
        3'd1: mTaken = mCcr[3];
        3'd2: mTaken = !mCcr[3];
        3'd3: mTaken = mCcr[2];
        3'd4: mTaken = !mCcr[2];
        3'd5: mTaken = mCcr[1];
        3'd6: mTaken = !mCcr[1];
        default: mTaken = mCcr[0];
      endcase
    end
  endtask

  // Full command from IDLE through handshake; called at a falling edge, returns at one
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] operand, input int holdCycles);
    checkOutput("idle_ready", busIf.req_ready, 1);
    checkOutput("idle_rsp_valid", busIf.rsp_valid, 0);
    busIf.req_valid   = 1'b1;
    busIf.req_op      = op;
    busIf.req_operand = operand;
    modelCommand(op, operand);
    @(posedge clock);
    @(negedge clock);
    busIf.req_op      = 3'($urandom_range(0, 7));
    busIf.req_operand = 8'($urandom_range(0, 255));
    if (op <= 3'd5) begin
      checkOutput("exec_ready", busIf.req_ready, 0);
      checkOutput("exec_rsp_valid", busIf.rsp_valid, 0);
      checkOutput("exec_alu_a", busIf.alu_a, mAluA);
      checkOutput("exec_alu_b", busIf.alu_b, mAluB);
      checkOutput("exec_alu_sel", busIf.alu_sel, mAluSel);
      @(posedge clock);
      @(negedge clock);
    end
    checkOutput("rsp_valid", busIf.rsp_valid, 1);
    checkOutput("rsp_data", busIf.rsp_data, mAcc);
    checkOutput("rsp_taken", busIf.rsp_taken, mTaken);
    checkOutput("rsp_ccr", busIf.ccr, mCcr);
    checkOutput("rsp_alu_regs", {busIf.alu_a, busIf.alu_b, busIf.alu_sel}, {mAluA, mAluB, mAluSel});
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput("hold_rsp_valid", busIf.rsp_valid, 1);
      checkOutput("hold_rsp_data", busIf.rsp_data, mAcc);
      checkOutput("hold_rsp_taken", busIf.rsp_taken, mTaken);
      checkOutput("hold_req_ready", busIf.req_ready, 0);
    end
    busIf.req_valid = 1'b0;
    busIf.rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    busIf.rsp_ready = 1'b0;
    checkOutput("done_rsp_valid", busIf.rsp_valid, 0);
    checkOutput("done_req_ready", busIf.req_ready, 1);
    checkOutput("done_acc", busIf.acc, mAcc);
  endtask

  // Reset values observed asynchronously, i.e. before any clock edge follows the reset
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_acc"}, busIf.acc, 8'h00);
    checkOutput({tag, "_ccr"}, busIf.ccr, 4'b0000);
    checkOutput({tag, "_req_ready"}, busIf.req_ready, 1);
    checkOutput({tag, "_rsp_valid"}, busIf.rsp_valid, 0);
    checkOutput({tag, "_rsp_taken"}, busIf.rsp_taken, 0);
    checkOutput({tag, "_alu_regs"}, {busIf.alu_a, busIf.alu_b, busIf.alu_sel}, 19'd0);
  endtask

  initial begin
    busIf.req_valid   = 1'b0;
    busIf.req_op      = 3'd0;
    busIf.req_operand = 8'h00;
    busIf.rsp_ready   = 1'b0;
    modelReset();

    #2 reset = 1'b0;
    #1 checkResetState("por");
    @(negedge clock);
    reset = 1'b1;

    // First command right after reset release, then the overflow-on-INC vector
    applyStimulus(3'd6, 8'h7F, 0);
    applyStimulus(3'd4, 8'($urandom_range(0, 255)), 0);
    checkOutput("inc_acc_80", busIf.acc, 8'h80);
    checkOutput("inc_ccr_1010", busIf.ccr, 4'b1010);

    // Carry out of ADD, then LOAD 00 keeps C
    applyStimulus(3'd6, 8'hFF, 0);
    applyStimulus(3'd0, 8'h01, 0);
    checkOutput("add_acc_00", busIf.acc, 8'h00);
    checkOutput("add_ccr_0101", busIf.ccr, 4'b0101);
    applyStimulus(3'd6, 8'h00, 0);
    checkOutput("load0_ccr_0101", busIf.ccr, 4'b0101);

    // SUB to zero, then branch tests on Z
    applyStimulus(3'd6, 8'h05, 0);
    applyStimulus(3'd1, 8'h05, 0);
    checkOutput("sub_ccr_0100", busIf.ccr, 4'b0100);
    applyStimulus(3'd7, 8'h03, 0);
    checkOutput("br_z_taken", busIf.rsp_taken, 1);
    applyStimulus(3'd7, 8'h04, 0);
    checkOutput("br_nz_taken", busIf.rsp_taken, 0);
    checkOutput("br_acc_00", busIf.acc, 8'h00);

    // Back-pressure on the response with a pending request
    applyStimulus(3'd6, 8'h42, 3);

    // Reset during EXEC of ADD 10 with acc 20
    applyStimulus(3'd6, 8'h20, 0);
    checkOutput("pre_exec_acc_20", busIf.acc, 8'h20);
    busIf.req_valid   = 1'b1;
    busIf.req_op      = 3'd0;
    busIf.req_operand = 8'h10;
    @(posedge clock);
    @(negedge clock);
    busIf.req_valid = 1'b0;
    #2 reset = 1'b0;
    #1 checkResetState("rst_exec");
    modelReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rst_exec_no_rsp", busIf.rsp_valid, 0);
    end
    reset = 1'b1;

    // Reset while a LOAD response is waiting
    busIf.req_valid   = 1'b1;
    busIf.req_op      = 3'd6;
    busIf.req_operand = 8'h9C;
    @(posedge clock);
    @(negedge clock);
    busIf.req_valid = 1'b0;
    checkOutput("pre_rst_rsp_valid", busIf.rsp_valid, 1);
    checkOutput("pre_rst_rsp_data", busIf.rsp_data, 8'h9C);
    #2 reset = 1'b0;
    #1 checkResetState("rst_resp");
    modelReset();
    @(negedge clock);
    reset = 1'b1;

    // Random command mix against the model
    for (int n = 0; n < 80; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: RESET_ACC, 8'h00, accumulator value loaded on reset.
REQ-002 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  command request valid.
REQ-005 Port: req_ready  output  1  block can accept a command.
REQ-006 Port: req_op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 INC, 5 DEC, 6 LOAD, 7 BRANCH-TEST.
REQ-007 Port: req_operand  input  8  ALU B operand, LOAD value, or condition code in bits [2:0] for BRANCH-TEST.
REQ-008 Port: alu_a  output  8  registered A operand to the external ALU (always the accumulator captured at accept).
REQ-009 Port: alu_b  output  8  registered B operand to the external ALU.
REQ-010 Port: alu_sel  output  3  registered ALU_Sel to the external ALU.
REQ-011 Port: alu_result  input  8  combinational ALU result.
REQ-012 Port: alu_nzvc  input  4  combinational ALU flags [N,Z,V,C].
REQ-013 Port: acc  output  8  accumulator register.
REQ-014 Port: ccr  output  4  condition code register [N,Z,V,C].
REQ-015 Port: rsp_valid  output  1  response valid.
REQ-016 Port: rsp_ready  input  1  response consumer ready.
REQ-017 Port: rsp_data  output  8  accumulator value at response time.
REQ-018 Port: rsp_taken  output  1  branch condition result; 0 for non-branch commands.

Function
REQ-019 The FSM SHALL have three states: IDLE, EXEC, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Accept SHALL occur on an edge with IDLE && req_valid; req_valid in EXEC/RESP SHALL be ignored.
REQ-021 Ops 0-5: at accept, alu_a<=acc, alu_b<=req_operand, alu_sel<=req_op, state->EXEC.
REQ-022 In EXEC, on the next edge, acc<=alu_result, ccr<=alu_nzvc (all four bits, including the V=C=0 the ALU produces for AND/OR), state->RESP.
REQ-023 ALU-op latency SHALL be 2 edges: rsp_valid asserts on the second edge after accept.
REQ-024 LOAD: at accept, acc<=req_operand, ccr[3]<=req_operand[7], ccr[2]<=(req_operand==0), ccr[1:0] unchanged, state->RESP (latency 1).
REQ-025 BRANCH-TEST: at accept, rsp_taken is latched from the current ccr using cond=req_operand[2:0]: 0 always, 1 N, 2 !N, 3 Z, 4 !Z, 5 V, 6 !V, 7 C; acc/ccr unchanged; state->RESP (latency 1).
REQ-026 In RESP, rsp_valid=1 and rsp_data=acc; rsp_data and rsp_taken SHALL hold stable until the handshake completes.
REQ-027 On an edge with RESP && rsp_ready, state->IDLE; the next command SHALL NOT be accepted on that same edge.
REQ-028 alu_a/alu_b/alu_sel SHALL hold their last values outside EXEC; LOAD/BRANCH-TEST SHALL NOT change them.
REQ-029 Arithmetic SHALL be performed only by the external ALU; no internal adder for ops 0-5.
REQ-030 rsp_taken SHALL be cleared at accept of any non-BRANCH-TEST command.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, acc=RESET_ACC, ccr=0000, alu_a=alu_b=00, alu_sel=000, rsp_valid=0, rsp_taken=0, req_ready=1.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the command with no acc/ccr update and no response.
REQ-033 After reset deassertion, a command SHALL be acceptable on the first rising edge.

Verification
REQ-034 Assert reset mid-sequence -> acc=00, ccr=0000, req_ready=1, rsp_valid=0 without waiting for a clock edge.
REQ-035 LOAD 7F, then INC -> the INC response 2 edges after accept: rsp_data=80, ccr=1010.
REQ-036 LOAD FF, ADD 01 -> acc=00, ccr=0101; then LOAD 00 -> ccr=0101 (C preserved), rsp_valid 1 edge after accept.
REQ-037 LOAD 05, SUB 05 -> acc=00, ccr=0100; BRANCH-TEST cond 3 -> rsp_taken=1; cond 4 -> rsp_taken=0; acc unchanged.
REQ-038 Hold rsp_ready=0 for 3 cycles in RESP with req_valid=1 -> rsp_valid/rsp_data stable, req_ready=0, no accept; IDLE after rsp_ready edge.
REQ-039 Assert reset during EXEC of ADD 10 with acc=20 -> acc=00, ccr=0000, no rsp_valid pulse.
